// File: rtl/associative_buffer_master.sv
`default_nettype none
// ============================================================================
// Module      : associative_buffer_master
// Description : Command initiator for the associative buffer. It accepts
//               lookup/update requests on a valid/ready channel and replays
//               them onto the buffer ctrl/key/data_in pins with pulse/gap
//               timing. It returns lookup results on a valid/ready response
//               channel and schedules buffer drain pulses (start_reading).
// Options     : WRITE_ACK_EN - when defined, LOAD/INCR/CLR also return a
//               response (resp_data=0, resp_hit=1) once their gap completes.
// Revision    : 1.0 - initial release
// ============================================================================
module associative_buffer_master #(
    parameter int DATA_WIDTH   = 8,
    parameter int KEY_WIDTH    = 4,
    parameter int READ_LATENCY = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic                  clk,
    input  logic                  sync_nreset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [KEY_WIDTH-1:0]  req_key,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_hit,
    input  logic                  drain_req,
    output logic [1:0]            buf_ctrl,
    output logic [KEY_WIDTH-1:0]  buf_key,
    output logic [DATA_WIDTH-1:0] buf_data_in,
    output logic                  buf_start_reading,
    input  logic [DATA_WIDTH-1:0] buf_data_out,
    input  logic                  buf_valid
);

    // Request opcodes; the buffer ctrl encoding shares the update codes and
    // uses 0 for "no operation".
    localparam logic [1:0] c_op_read   = 2'd0;
    localparam logic [1:0] c_ctrl_none = 2'd0;

    // Counter reload values: the counter holds "cycles remaining minus one",
    // so a 4-bit counter covers phases of 1..16 cycles.
    localparam logic [3:0] c_gap_load = 4'(GAP_CYCLES - 1);
    localparam logic [3:0] c_rd_load  = 4'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_GAP     = 3'd2,
        S_WAIT_RD = 3'd3,
        S_RESP    = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_next;
    logic       r_drain_pending;
    logic       w_drain_pending_next;
    logic       w_accept;
    logic       w_issue;
    logic       w_capture_rd;
    logic       w_capture_ack;
    logic       w_req_ready_next;

    // Next-state, counter reload and capture strobes for the command sequencer.
    always_comb begin
        w_next_state  = r_state;
        w_cnt_next    = (r_cnt != 4'd0) ? (r_cnt - 4'd1) : 4'd0;
        w_accept      = req_valid & req_ready & (r_state == S_IDLE);
        w_issue       = 1'b0;
        w_capture_rd  = 1'b0;
        w_capture_ack = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A pending drain always beats a new request; req_ready is
                // already low whenever the drain flag is set.
                if (r_drain_pending) begin
                    w_next_state = S_DRAIN;
                    w_cnt_next   = 4'd0;
                end else if (w_accept) begin
                    if (req_op == c_op_read) begin
                        w_next_state = S_WAIT_RD;
                        w_cnt_next   = c_rd_load;
                    end else begin
                        w_next_state = S_ISSUE;
                        w_cnt_next   = 4'd0;
                        w_issue      = 1'b1;
                    end
                end
            end

            S_ISSUE: begin
                w_next_state = S_GAP;
                w_cnt_next   = c_gap_load;
            end

            S_GAP: begin
                if (r_cnt == 4'd0) begin
`ifdef WRITE_ACK_EN
                    w_next_state  = S_RESP;
                    w_capture_ack = 1'b1;
`else
                    w_next_state  = S_IDLE;
`endif
                    w_cnt_next    = 4'd0;
                end
            end

            S_WAIT_RD: begin
                // Key has been stable for READ_LATENCY+1 cycles at this edge.
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                    w_capture_rd = 1'b1;
                    w_cnt_next   = 4'd0;
                end
            end

            S_RESP: begin
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = 4'd0;
                end
            end

            S_DRAIN: begin
                w_next_state = S_IDLE;
                w_cnt_next   = 4'd0;
            end

            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = 4'd0;
            end
        endcase

        // A drain_req arriving while DRAIN clears the flag must survive, so
        // the set term is ORed in after the clear.
        w_drain_pending_next = drain_req |
                               (r_drain_pending & (r_state != S_DRAIN));

        w_req_ready_next = (w_next_state == S_IDLE) & ~w_drain_pending_next;
    end

    // State, phase counter and drain flag registers.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            r_state         <= S_IDLE;
            r_cnt           <= 4'd0;
            r_drain_pending <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_cnt           <= w_cnt_next;
            r_drain_pending <= w_drain_pending_next;
        end
    end

    // Registered outputs; key/data only move on accept and responses only
    // move on capture, so both hold across all other states.
    always_ff @(posedge clk) begin
        if (!sync_nreset) begin
            req_ready         <= 1'b0;
            resp_valid        <= 1'b0;
            resp_data         <= '0;
            resp_hit          <= 1'b0;
            buf_ctrl          <= c_ctrl_none;
            buf_key           <= '0;
            buf_data_in       <= '0;
            buf_start_reading <= 1'b0;
        end else begin
            req_ready         <= w_req_ready_next;
            resp_valid        <= (w_next_state == S_RESP);
            buf_start_reading <= (w_next_state == S_DRAIN);
            buf_ctrl          <= w_issue ? req_op : c_ctrl_none;

            if (w_accept) begin
                buf_key <= req_key;
                if (req_op != c_op_read) begin
                    buf_data_in <= req_data;
                end
            end

            if (w_capture_rd) begin
                resp_data <= buf_data_out;
                resp_hit  <= buf_valid;
            end else if (w_capture_ack) begin
                resp_data <= '0;
                resp_hit  <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_associative_buffer_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_associative_buffer_master
// Description : Self-checking bench for associative_buffer_master. A small
//               associative-buffer stub sits on the buf_* pins, and a
//               request-level reference model predicts every lookup result.
//               Honours WRITE_ACK_EN when it is defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_associative_buffer_master;

    localparam int DW = 8;
    localparam int KW = 4;
    localparam int RL = 1;
    localparam int GC = 1;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_INCR = 2'd2;
    localparam logic [1:0] OP_CLR  = 2'd3;

`ifdef WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sync_nreset;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [KW-1:0] req_key;
    logic [DW-1:0] req_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_hit;
    logic          drain_req;
    logic [1:0]    buf_ctrl;
    logic [KW-1:0] buf_key;
    logic [DW-1:0] buf_data_in;
    logic          buf_start_reading;
    logic [DW-1:0] buf_data_out;
    logic          buf_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Request-level reference model of the buffer contents.
    logic [DW-1:0] ref_mem [16];
    bit            ref_vld [16];

    // Pin-level buffer stub driven by the DUT's buf_* outputs.
    logic [DW-1:0] stub_mem [16];
    logic          stub_vld [16];
    logic          stub_clr;

    always #5 clk = ~clk;

    associative_buffer_master #(
        .DATA_WIDTH  (DW),
        .KEY_WIDTH   (KW),
        .READ_LATENCY(RL),
        .GAP_CYCLES  (GC)
    ) dut (
        .clk              (clk),
        .sync_nreset      (sync_nreset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_key          (req_key),
        .req_data         (req_data),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_data        (resp_data),
        .resp_hit         (resp_hit),
        .drain_req        (drain_req),
        .buf_ctrl         (buf_ctrl),
        .buf_key          (buf_key),
        .buf_data_in      (buf_data_in),
        .buf_start_reading(buf_start_reading),
        .buf_data_out     (buf_data_out),
        .buf_valid        (buf_valid)
    );

    // Buffer stub: applies each ctrl pulse at the clock edge.
    always @(posedge clk) begin
        if (stub_clr) begin
            for (int i = 0; i < 16; i++) begin
                stub_mem[i] <= '0;
                stub_vld[i] <= 1'b0;
            end
        end else begin
            case (buf_ctrl)
                OP_LOAD: begin
                    stub_mem[buf_key] <= buf_data_in;
                    stub_vld[buf_key] <= 1'b1;
                end
                OP_INCR: stub_mem[buf_key] <= stub_mem[buf_key] + 8'd1;
                OP_CLR: begin
                    stub_mem[buf_key] <= '0;
                    stub_vld[buf_key] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign buf_data_out = stub_mem[buf_key];
    assign buf_valid    = stub_vld[buf_key];

    // Waits (bounded) for req_ready at a falling edge, presents one request
    // for one cycle and applies its effect to the reference model.
    task automatic send_req(input logic [1:0] op, input logic [3:0] k,
                            input logic [7:0] d, output bit ok);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        ok = (req_ready === 1'b1);
        if (ok) begin
            req_valid = 1'b1;
            req_op    = op;
            req_key   = k;
            req_data  = d;
            @(negedge clk);
            req_valid = 1'b0;
            req_op    = 2'($urandom_range(0, 3));
            req_key   = 4'($urandom_range(0, 15));
            req_data  = 8'($urandom_range(0, 255));
            case (op)
                OP_LOAD: begin ref_mem[k] = d; ref_vld[k] = 1'b1; end
                OP_INCR: ref_mem[k] = ref_mem[k] + 8'd1;
                OP_CLR:  begin ref_mem[k] = 8'd0; ref_vld[k] = 1'b0; end
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        logic [29:0] obs;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {req_ready, resp_valid, resp_data, resp_hit, buf_ctrl,
                   buf_key, buf_data_in, buf_start_reading};
            n_checks++;
            if (obs !== 30'd0) begin
                n_errors++;
                $display("FAIL reset_values cycle %0d: got %h, expected 0", i, obs);
            end
        end
        sync_nreset = 1'b1;
        @(negedge clk);
        stub_clr = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_release_ready: got %b, expected 1", req_ready);
        end
        n_checks++;
        if (buf_ctrl !== OP_READ || buf_key !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_no_accept: got ctrl=%0d key=%0d, expected ctrl=0 key=0",
                     buf_ctrl, buf_key);
        end
        req_valid = 1'b0;
    endtask

    task automatic test_load(input logic [3:0] k, input logic [7:0] d);
        bit   ok;
        int   last;
        logic exp_ready;
        logic exp_resp;
        resp_ready = 1'b1;
        send_req(OP_LOAD, k, d, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL load_accept: got no req_ready, expected accept");
        end
        last = GC + 2 + (ACK ? 1 : 0);
        for (int c = 1; c <= last; c++) begin
            exp_ready = (c == last);
            exp_resp  = ACK && (c == GC + 2);
            n_checks++;
            if (buf_ctrl !== ((c == 1) ? OP_LOAD : OP_READ)) begin
                n_errors++;
                $display("FAIL load_ctrl cycle %0d: got %0d, expected %0d",
                         c, buf_ctrl, (c == 1) ? 1 : 0);
            end
            n_checks++;
            if (buf_key !== k || buf_data_in !== d) begin
                n_errors++;
                $display("FAIL load_key_data cycle %0d: got %h/%h, expected %h/%h",
                         c, buf_key, buf_data_in, k, d);
            end
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_errors++;
                $display("FAIL load_ready cycle %0d: got %b, expected %b", c, req_ready, exp_ready);
            end
            n_checks++;
            if (resp_valid !== exp_resp) begin
                n_errors++;
                $display("FAIL load_resp_valid cycle %0d: got %b, expected %b",
                         c, resp_valid, exp_resp);
            end
            if (exp_resp) begin
                n_checks++;
                if (resp_data !== 8'h00 || resp_hit !== 1'b1) begin
                    n_errors++;
                    $display("FAIL load_ack: got %h/%b, expected 00/1", resp_data, resp_hit);
                end
            end
            if (c < last) @(negedge clk);
        end
    endtask

    task automatic test_read(input logic [3:0] k, input int stall);
        bit            ok;
        int            last;
        logic [DW-1:0] exp_d;
        logic          exp_h;
        exp_d = ref_mem[k];
        exp_h = ref_vld[k];
        resp_ready = (stall == 0);
        send_req(OP_READ, k, 8'h00, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL read_accept: got no req_ready, expected accept");
        end
        last = RL + 2 + stall;
        for (int c = 1; c <= last; c++) begin
            n_checks++;
            if (buf_ctrl !== OP_READ || buf_key !== k) begin
                n_errors++;
                $display("FAIL read_pins cycle %0d: got ctrl=%0d key=%h, expected 0/%h",
                         c, buf_ctrl, buf_key, k);
            end
            n_checks++;
            if (resp_valid !== (c >= RL + 2)) begin
                n_errors++;
                $display("FAIL read_resp_valid cycle %0d: got %b, expected %b",
                         c, resp_valid, (c >= RL + 2));
            end
            if (c >= RL + 2) begin
                n_checks++;
                if (resp_data !== exp_d || resp_hit !== exp_h || req_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL read_resp cycle %0d: got %h/%b rdy=%b, expected %h/%b rdy=0",
                             c, resp_data, resp_hit, req_ready, exp_d, exp_h);
                end
            end
            if (c == last) resp_ready = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL read_release: got valid=%b ready=%b, expected valid=0 ready=1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_read_hit();
        test_load(4'd8, 8'hDB);
        test_read(4'd8, 0);
    endtask

    task automatic test_drain();
        bit ok;
        int pulses, pulse_cyc, resp_cyc, ready_cyc;
        pulses = 0; pulse_cyc = -1; resp_cyc = -1; ready_cyc = -1;
        resp_ready = 1'b1;
        send_req(OP_READ, 4'd1, 8'h00, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL drain_accept: got no req_ready, expected accept");
        end
        for (int i = 0; i < 14; i++) begin
            if (resp_valid === 1'b1 && resp_cyc < 0) resp_cyc = i;
            if (buf_start_reading === 1'b1) begin
                pulses++;
                pulse_cyc = i;
            end
            if (req_ready === 1'b1 && ready_cyc < 0) ready_cyc = i;
            drain_req = (i == 0 || i == 2);
            @(negedge clk);
        end
        drain_req = 1'b0;
        n_checks++;
        if (pulses != 1) begin
            n_errors++;
            $display("FAIL drain_pulse_count: got %0d, expected 1", pulses);
        end
        n_checks++;
        if (resp_cyc != RL + 1) begin
            n_errors++;
            $display("FAIL drain_resp_cycle: got %0d, expected %0d", resp_cyc, RL + 1);
        end
        n_checks++;
        if (!(pulse_cyc > resp_cyc && ready_cyc > pulse_cyc)) begin
            n_errors++;
            $display("FAIL drain_order: got resp=%0d pulse=%0d ready=%0d, expected resp<pulse<ready",
                     resp_cyc, pulse_cyc, ready_cyc);
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        resp_ready = 1'b1;
        send_req(OP_READ, 4'd1, 8'h00, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL midop_accept: got no req_ready, expected accept");
        end
        drain_req = 1'b1;
        @(negedge clk);
        drain_req   = 1'b0;
        sync_nreset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || buf_ctrl !== OP_READ || req_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL midop_in_reset: got valid=%b ctrl=%0d ready=%b, expected 0/0/0",
                         resp_valid, buf_ctrl, req_ready);
            end
        end
        sync_nreset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (resp_valid !== 1'b0 || buf_start_reading !== 1'b0) begin
                n_errors++;
                $display("FAIL midop_after_release cycle %0d: got valid=%b drain=%b, expected 0/0",
                         i, resp_valid, buf_start_reading);
            end
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL midop_ready: got %b, expected 1", req_ready);
        end
        test_load(4'd2, 8'h3C);
    endtask

    task automatic test_random();
        bit            ok;
        logic [1:0]    op;
        logic [3:0]    k;
        logic [7:0]    d;
        logic [DW-1:0] exp_d;
        logic          exp_h;
        int            n, stall;
        for (int t = 0; t < 40; t++) begin
            op    = 2'($urandom_range(0, 3));
            k     = 4'($urandom_range(0, 3));
            d     = 8'($urandom_range(0, 255));
            stall = $urandom_range(0, 3);
            exp_d = ref_mem[k];
            exp_h = ref_vld[k];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            resp_ready = (stall == 0);
            send_req(op, k, d, ok);
            n_checks++;
            if (!ok) begin
                n_errors++;
                $display("FAIL rand_accept %0d: got no req_ready, expected accept", t);
            end
            if (op == OP_READ || ACK) begin
                if (op != OP_READ) begin
                    exp_d = 8'h00;
                    exp_h = 1'b1;
                end
                n = 0;
                while (resp_valid !== 1'b1 && n < 64) begin
                    @(negedge clk);
                    n++;
                end
                n_checks++;
                if (resp_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL rand_resp_timeout %0d: got no resp_valid, expected response", t);
                end
                for (int s = 0; s <= stall; s++) begin
                    n_checks++;
                    if (resp_data !== exp_d || resp_hit !== exp_h) begin
                        n_errors++;
                        $display("FAIL rand_resp %0d op=%0d key=%0d: got %h/%b, expected %h/%b",
                                 t, op, k, resp_data, resp_hit, exp_d, exp_h);
                    end
                    if (s == stall) resp_ready = 1'b1;
                    @(negedge clk);
                end
                n_checks++;
                if (resp_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL rand_resp_drop %0d: got %b, expected 0", t, resp_valid);
                end
            end
        end
        resp_ready = 1'b1;
    endtask

    initial begin
        sync_nreset = 1'b0;
        stub_clr    = 1'b1;
        req_valid   = 1'b1;
        req_op      = OP_LOAD;
        req_key     = 4'd3;
        req_data    = 8'hAA;
        resp_ready  = 1'b1;
        drain_req   = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = 8'h00;
            ref_vld[i] = 1'b0;
        end

        test_reset();
        test_load(4'd1, 8'h0F);
        test_read_hit();
        test_read(4'd5, 5);
        test_drain();
        test_reset_midop();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected run to complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
